veririsc_mem_responder: RTL
===========================

Name: veririsc_mem_responder

Overview:
- Memory-side responder to the VeriRISC controller's bus strobes.
- Holds program and data words in a single array and returns read data one cycle after `rd`.
- Commits exactly one write per `wr` assertion, taking the data the accumulator drives while `data_e` is high.
- Sits between the address mux (`sel`-selected PC or IR operand) and the shared data bus; also provides a preload port for test programs.

Parameters:
- addr_width, 5, memory address width; depth = 2**addr_width words.
- data_width, 8, word width; opcode is data[data_width-1 -: 3].
- init_zero, 0, when 1, reset also clears the array (one word per cycle, sequenced).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- addr  input  addr_width  word address from the address mux.
- rd  input  1  controller read strobe.
- wr  input  1  controller write strobe.
- data_e  input  1  accumulator is driving data_in.
- data_in  input  data_width  accumulator data for writes.
- data_out  output  data_width  registered read data.
- data_oe  output  1  data_out is valid and drives the bus.
- pl_en  input  1  preload write enable (bench/loader).
- pl_addr  input  addr_width  preload address.
- pl_data  input  data_width  preload data.
- busy  output  1  reset-clear in progress (init_zero=1 only).
- err  output  1  sticky protocol error.

Behaviour:
- Reset (rst high at a clk edge):
  - data_out=0, data_oe=0, err=0, wr_q=0.
  - With init_zero=1: busy=1 and state goes to CLEAR. With init_zero=0: busy=0 and the array is untouched.
- States:
  - IDLE: normal operation.
  - CLEAR: writes 0 to address clr_cnt, clr_cnt increments; after the depth-1 write, go to IDLE and drop busy.
  - In CLEAR, rd/wr/pl_en are ignored and data_oe=0.
  - rst during CLEAR restarts CLEAR at address 0.
- Read:
  - If rd=1 at edge N (IDLE, no write this cycle), then data_out=mem[addr] and data_oe=1 after edge N. Latency is 1 cycle.
  - data_oe drops the cycle after rd=0.
  - Holding rd across phases keeps re-reading, so an addr change is visible one cycle later.
- Write:
  - wr_q registers wr each cycle; the write fires only when wr=1 and wr_q=0 (rising edge): mem[addr] <= data_in.
  - A wr held high for several cycles writes once.
  - wr rising while data_e=0: the write is still committed and err is set.
- Simultaneous rd and write-fire in the same cycle: the write is performed, the read is suppressed (data_oe=0 next cycle, data_out holds its previous value), and err is set.
- A read in the cycle after a write to the same address returns the new data.
- Preload:
  - pl_en=1 writes mem[pl_addr] <= pl_data.
  - pl_en has priority over a controller write in the same cycle; the controller write is dropped, err is set, and wr_q still updates.
  - A read in the same cycle as pl_en proceeds and returns the old contents.
- err is sticky until rst.
- Address is always in range; no wrap logic is needed beyond the natural addr_width.

Test Plan:
- rst, then pl_en with pl_addr=3, pl_data=0xA5; next cycle rd=1, addr=3 → one cycle later data_oe=1 and data_out=0xA5; rd=0 → data_oe=0 the next cycle.
- wr=1 for 3 cycles at addr=7 with data_e=1, data_in=0x11, then 0x22, 0x33 → mem[7]=0x11 only (one write per assertion); err=0.
- wr rises with data_e=0 at addr=2, data_in=0x5C → mem[2]=0x5C and err=1; err holds until rst and clears on rst.
- rd=1 and wr rising in the same cycle at addr=4, data_in=0x9E → mem[4]=0x9E, data_oe=0 next cycle, data_out unchanged, err=1; then rd at addr=4 → 0x9E.
- pl_en at pl_addr=1 (0x01) in the same cycle as wr rising at addr=1 (0xFF) → mem[1]=0x01, err=1.
- init_zero=1: preload address 31 with 0xEE, then pulse rst → busy=1 for 32 cycles; rd ignored meanwhile; after busy=0, rd at addr=31 → 0x00. rst asserted at clr_cnt=10 → CLEAR restarts at 0 (busy for 32 more cycles).

Source files
------------

// File: rtl/veririsc_mem_responder.sv
// veririsc_mem_responder: word memory that answers the VeriRISC controller's rd/wr strobes.
// Read data is registered, so data_out/data_oe follow rd by one cycle.
// A write fires once per rising edge of wr. pl_en lets a loader preload words.
// An optional reset-time clear (init_zero) holds busy for depth cycles.
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   addr, rd, wr                   controller address and strobes
//   data_e, data_in                accumulator drive enable and write data
//   data_out, data_oe              registered read data and bus drive enable
//   pl_en, pl_addr, pl_data        preload write port
//   busy                           reset-time clear in progress
//   err                            sticky protocol error
module veririsc_mem_responder #(
   parameter int addr_width = 5,
   parameter int data_width = 8,
   parameter bit init_zero  = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [addr_width-1:0] addr,
   input  logic                  rd,
   input  logic                  wr,
   input  logic                  data_e,
   input  logic [data_width-1:0] data_in,
   output logic [data_width-1:0] data_out,
   output logic                  data_oe,
   input  logic                  pl_en,
   input  logic [addr_width-1:0] pl_addr,
   input  logic [data_width-1:0] pl_data,
   output logic                  busy,
   output logic                  err
);

   localparam int depth = 2 ** addr_width;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t                state_q;
   logic [addr_width-1:0] clr_cnt_q;
   logic                  wr_q;
   logic [data_width-1:0] data_out_q;
   logic                  data_oe_q;
   logic                  busy_q;
   logic                  err_q;

   logic [data_width-1:0] mem [depth];

   // Controller write happens only on the rising edge of wr.
   logic                  wr_fire;
   assign wr_fire = wr & ~wr_q;

   // Single write port shared by clear, preload and controller writes.
   // Preload outranks the controller; nothing is written while rst is high
   // so that a reset without init_zero leaves the array untouched.
   logic                  mem_we;
   logic [addr_width-1:0] mem_waddr;
   logic [data_width-1:0] mem_wdata;

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = addr;
      mem_wdata = data_in;
      if (!rst) begin
         if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = '0;
         end else if (pl_en) begin
            mem_we    = 1'b1;
            mem_waddr = pl_addr;
            mem_wdata = pl_data;
         end else if (wr_fire) begin
            mem_we    = 1'b1;
            mem_waddr = addr;
            mem_wdata = data_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_out_q <= '0;
         data_oe_q  <= 1'b0;
         err_q      <= 1'b0;
         wr_q       <= 1'b0;
         clr_cnt_q  <= '0;
         if (init_zero) begin
            state_q <= ST_CLEAR;
            busy_q  <= 1'b1;
         end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
         end
      end else begin
         wr_q <= wr;
         case (state_q)
            ST_CLEAR: begin
               data_oe_q <= 1'b0;
               clr_cnt_q <= clr_cnt_q + 1'b1;
               // Last word of the array has just been cleared.
               if (&clr_cnt_q) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               // Error cases for a firing write: no accumulator drive,
               // collision with a read, or dropped in favour of a preload.
               if (wr_fire && (!data_e || rd || pl_en)) begin
                  err_q <= 1'b1;
               end
               // Reads colliding with a write are suppressed; data_out holds.
               // A same-cycle preload does not block the read, which sees the
               // pre-write contents.
               if (rd && !wr_fire) begin
                  data_out_q <= mem[addr];
                  data_oe_q  <= 1'b1;
               end else begin
                  data_oe_q  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign data_out = data_out_q;
   assign data_oe  = data_oe_q;
   assign busy     = busy_q;
   assign err      = err_q;

endmodule
